// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - opcode encodings and helpers shared by the multiply/divide unit
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } mdOp_e;

    function automatic logic isMult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic isDiv(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// rtl/md_unit_calc.sv - combinational multiply/divide datapath producing HI/LO and a divide-by-zero flag
module md_calc
    import md_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    logic [63:0] prod;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        hi   = '0;
        lo   = '0;
        dz   = 1'b0;
        prod = '0;
        absA = A;
        absB = B;
        quo  = '0;
        rem  = '0;
        case (mdOp_e'(MDOp))
            MD_MULT: begin
                prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
                {hi, lo} = prod;
            end
            MD_MULTU: begin
                prod = {32'd0, A} * {32'd0, B};
                {hi, lo} = prod;
            end
            MD_DIV, MD_DIVU: begin
                dz = (B == 32'd0);
                if (MDOp == MD_DIV) begin
                    absA = A[31] ? (32'd0 - A) : A;
                    absB = B[31] ? (32'd0 - B) : B;
                end
                // Magnitude divide; 0x80000000 / -1 falls out as 0x80000000 rem 0.
                if (!dz) begin
                    quo = absA / absB;
                    rem = absA % absB;
                end
                if (MDOp == MD_DIV) begin
                    lo = (A[31] ^ B[31]) ? (32'd0 - quo) : quo;
                    hi = A[31] ? (32'd0 - rem) : rem;
                end else begin
                    lo = quo;
                    hi = rem;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed multi-cycle latency
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt;
    logic [31:0]     tmpHI;
    logic [31:0]     tmpLO;
    logic            tmpDZ;
    logic [31:0]     calcHi;
    logic [31:0]     calcLo;
    logic            calcDz;

    md_calc uCalc (
        .A    (A),
        .B    (B),
        .MDOp (MDOp),
        .hi   (calcHi),
        .lo   (calcLo),
        .dz   (calcDz)
    );

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            tmpHI <= '0;
            tmpLO <= '0;
            tmpDZ <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else if (busy) begin
            // Any start while busy is dropped; HI/LO only change at the final edge.
            if (cnt == CntW'(1) && !tmpDZ) begin
                HI <= tmpHI;
                LO <= tmpLO;
            end
            cnt <= cnt - CntW'(1);
        end else if (start) begin
            if (isMult(MDOp) || isDiv(MDOp)) begin
                tmpHI <= calcHi;
                tmpLO <= calcLo;
                tmpDZ <= calcDz;
                cnt   <= isMult(MDOp) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            end else if (MDOp == MD_MTHI) begin
                HI <= A;
            end else if (MDOp == MD_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule
